lsu_mem_port: RTL



---
 rtl/lsu_mem_port.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_port.sv
// Data-memory port of the load/store unit: turns one core load/store into a
// req/gnt/rvalid memory transaction, builds byte enables and replicated
// store data, and extends load data for the register-file write bus.
module lsu_mem_port #(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    input  logic             req_store_i,
    input  logic [2:0]       req_funct3_i,
    input  logic [Width-1:0] req_addr_i,
    input  logic [Width-1:0] req_wdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [Width-1:0] rdata_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [3:0]       mem_be_o,
    output logic [Width-1:0] mem_addr_o,
    output logic [Width-1:0] mem_wdata_o,
    input  logic             mem_gnt_i,
    input  logic             mem_rvalid_i,
    input  logic [Width-1:0] mem_rdata_i
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, ERR} state_t;

    state_t           state_q, state_d;
    logic             op_store_q;
    logic [2:0]       funct3_q;
    logic [Width-1:0] addr_q;
    logic [Width-1:0] wdata_q;
    logic [Width-1:0] rdata_q;

    // Legal funct3 for the direction, with natural alignment for H and W.
    function automatic logic req_legal(input logic store, input logic [2:0] f3,
                                       input logic [1:0] a);
        logic ok;
        case (f3)
            3'b000:  ok = 1'b1;
            3'b001:  ok = ~a[0];
            3'b010:  ok = (a == 2'b00);
            3'b100:  ok = ~store;
            3'b101:  ok = ~store & ~a[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte enables for a store; sub-word stores select their lanes by address.
    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] be;
        case (f3)
            3'b000:  be = 4'b0001 << a;
            3'b001:  be = 4'b0011 << {a[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data replicated across lanes so the enabled lanes carry it.
    function automatic logic [Width-1:0] store_data(input logic [2:0] f3,
                                                    input logic [Width-1:0] wd);
        logic [Width-1:0] d;
        case (f3)
            3'b000:  d = {(Width/8){wd[7:0]}};
            3'b001:  d = {(Width/16){wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    // Bring the addressed lane down to bit 0, then sign- or zero-extend.
    function automatic logic [Width-1:0] load_extend(input logic [2:0] f3,
                                                     input logic [1:0] a,
                                                     input logic [Width-1:0] word);
        logic [Width-1:0] s;
        logic [Width-1:0] r;
        s = word >> {a, 3'b000};
        case (f3)
            3'b000:  r = {{(Width-8){s[7]}}, s[7:0]};
            3'b001:  r = {{(Width-16){s[15]}}, s[15:0]};
            3'b100:  r = {{(Width-8){1'b0}}, s[7:0]};
            3'b101:  r = {{(Width-16){1'b0}}, s[15:0]};
            default: r = word;
        endcase
        return r;
    endfunction

    // State register and load result; reset aborts any open transaction.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == WAIT && mem_rvalid_i) begin
                rdata_q <= load_extend(funct3_q, addr_q[1:0], mem_rdata_i);
            end
        end
    end

    // Capture the request when it is accepted in IDLE; held for the transaction.
    always_ff @(posedge clk_i) begin
        if (state_q == IDLE && req_valid_i) begin
            op_store_q <= req_store_i;
            funct3_q   <= req_funct3_i;
            addr_q     <= req_addr_i;
            wdata_q    <= req_wdata_i;
        end
    end

    // Next-state and memory/handshake outputs; memory side is quiet outside REQ.
    always_comb begin
        state_d     = state_q;
        done_o      = 1'b0;
        err_o       = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'b0000;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    if (req_legal(req_store_i, req_funct3_i, req_addr_i[1:0])) begin
                        state_d = REQ;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            REQ: begin
                mem_req_o  = 1'b1;
                mem_we_o   = op_store_q;
                mem_addr_o = {addr_q[Width-1:2], 2'b00};
                if (op_store_q) begin
                    mem_be_o    = store_be(funct3_q, addr_q[1:0]);
                    mem_wdata_o = store_data(funct3_q, wdata_q);
                end else begin
                    mem_be_o    = 4'b1111;
                end
                if (mem_gnt_i) begin
                    state_d = op_store_q ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            ERR: begin
                err_o   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o  = (state_q != IDLE);
    assign rdata_o = rdata_q;

endmodule
